cache_fill_fsm: RTL and testbench

Miss-handling controller that sits between the I-/D-cache arrays and the multi-cycle main memory. On a cache miss it issues one pipelined read per cycle for every 16-bit word of the 16-byte block, collects the words as the memory's 4-cycle-latency valid pulses return, and writes each word into the data array. On the last word it writes the tag array and releases the pipeline stall. It is the requesting end of the memory read protocol: enable/addr out, data/valid back.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_fill_fsm_if.sv | 38 +++
 rtl/block_word_counter.sv | 58 +++++
 rtl/cache_fill_fsm.sv | 151 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache miss-fill controller.
//   WORDS_PER_BLOCK : 16-bit words per cache block (power of two)
//   WORD_IDX_W      : width of a word index inside a block
//   BLOCK_OFFSET_W  : byte-offset width of a block (16-byte blocks)
//   CNT_W           : width of the fill counters (must be able to hold 8)
//   MEM_LATENCY     : main-memory read latency; informational only
//   fill_state_e    : fill controller state encoding
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int BLOCK_OFFSET_W  = WORD_IDX_W + 1;
  localparam int CNT_W           = WORD_IDX_W + 1;
  localparam int DATA_W          = 16;
  localparam int MEM_LATENCY     = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage : cache_pkg

// File: rtl/cache_fill_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_if
// Main-memory read bus between the fill controller (master) and memory (slave).
//   mem_enable        : request strobe, one read per cycle
//   mem_wr            : write select, always 0 from the fill controller
//   memory_address    : request byte address
//   memory_data_in    : returned read data
//   memory_data_valid : read data valid, returns in request order
// -----------------------------------------------------------------------------
interface cache_fill_fsm_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
);

  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [DATA_W-1:0]     memory_data_in;
  logic                  memory_data_valid;

  modport master (
    output mem_enable,
    output mem_wr,
    output memory_address,
    input  memory_data_in,
    input  memory_data_valid
  );

  modport slave (
    input  mem_enable,
    input  mem_wr,
    input  memory_address,
    output memory_data_in,
    output memory_data_valid
  );

endinterface : cache_fill_fsm_if

// File: rtl/block_word_counter.sv
// -----------------------------------------------------------------------------
// block_word_counter
// Counts words of one block fill and produces the wrapped word index.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count at 0 and capture start_idx
//   start_idx : index of the first word of the fill
//   inc       : advance by one word
//   idx       : (start_idx + count) modulo WORDS_PER_BLOCK
//   last      : count == WORDS_PER_BLOCK-1 (the current word is the final one)
//   done      : count == WORDS_PER_BLOCK (all words counted)
// -----------------------------------------------------------------------------
module block_word_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [WORD_IDX_W-1:0] start_idx,
  input  logic                  inc,
  output logic [WORD_IDX_W-1:0] idx,
  output logic                  last,
  output logic                  done
);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [WORD_IDX_W-1:0] start_q, start_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    start_d = start_q;
    if (clr) begin
      count_d = '0;
      start_d = start_idx;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      start_q <= '0;
    end else begin
      count_q <= count_d;
      start_q <= start_d;
    end
  end

  // Index wraps naturally by truncating to WORD_IDX_W bits.
  assign idx  = start_q + count_q[WORD_IDX_W-1:0];
  assign last = (count_q == CNT_W'(WORDS_PER_BLOCK - 1));
  assign done = (count_q == CNT_W'(WORDS_PER_BLOCK));

endmodule : block_word_counter

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// Miss-handling controller: on a cache miss it issues one read per cycle for
// every 16-bit word of the 16-byte block, writes each returned word into the
// data array, and writes the tag array with the final word.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   miss_detected    : miss request, sampled only while idle
//   miss_address     : byte address of the missing access
//   fsm_busy         : fill in progress (pipeline stall)
//   write_data_array : strobe, write data_to_cache at word_offset
//   write_tag_array  : strobe, coincident with the final data write
//   word_offset      : word index of the current data write (0 otherwise)
//   data_to_cache    : returned word, straight from memory_data_in
//   mem              : memory read bus (master side)
//
// Configuration
//   CACHE_FILL_CRITICAL_FIRST_EN : when defined, the fill starts at the
//   requested word (miss_address[3:1]) and wraps; otherwise it starts at 0.
// -----------------------------------------------------------------------------
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_detected,
  input  logic [ADDR_WIDTH-1:0]   miss_address,
  output logic                    fsm_busy,
  output logic                    write_data_array,
  output logic                    write_tag_array,
  output logic [WORD_IDX_W-1:0]   word_offset,
  output logic [DATA_W-1:0]       data_to_cache,
  cache_fill_fsm_if.master        mem
);

  localparam int TAG_W = ADDR_WIDTH - BLOCK_OFFSET_W;

  fill_state_e           state_q, state_d;
  logic [TAG_W-1:0]      base_q, base_d;        // block address without offset
  logic                  mem_enable_q, mem_enable_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [WORD_IDX_W-1:0] start_idx;
  logic                  fill_clr;
  logic                  issue_inc, recv_inc;
  logic [WORD_IDX_W-1:0] issue_idx, recv_idx, issue_idx_next;
  logic                  issue_last, issue_done;
  logic                  recv_last, recv_done;
  logic                  data_write;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  assign start_idx = miss_address[BLOCK_OFFSET_W-1:1];
  wire unused_byte_bit = miss_address[0];
`else
  assign start_idx = '0;
  wire unused_offset_bits = ^miss_address[BLOCK_OFFSET_W-1:0];
`endif

  block_word_counter u_issue_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (fill_clr),
    .start_idx (start_idx),
    .inc       (issue_inc),
    .idx       (issue_idx),
    .last      (issue_last),
    .done      (issue_done)
  );

  block_word_counter u_recv_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (fill_clr),
    .start_idx (start_idx),
    .inc       (recv_inc),
    .idx       (recv_idx),
    .last      (recv_last),
    .done      (recv_done)
  );

  assign issue_idx_next = issue_idx + WORD_IDX_W'(1);

  // Read data returns in request order, so the receive counter alone names
  // the word that is arriving.
  assign data_write = (state_q == FILL) && mem.memory_data_valid && !recv_done;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    mem_enable_d = 1'b0;
    mem_addr_d   = '0;
    fill_clr     = 1'b0;
    issue_inc    = 1'b0;
    recv_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d      = FILL;
          base_d       = miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_W];
          fill_clr     = 1'b1;
          // The first request is registered on the accepting edge so the bus
          // is busy from the very first FILL cycle.
          mem_enable_d = 1'b1;
          mem_addr_d   = {miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_W], start_idx, 1'b0};
        end
      end
      FILL: begin
        // The word currently on the bus counts as issued this cycle.
        issue_inc = mem_enable_q && !issue_done;
        if (issue_inc && !issue_last) begin
          mem_enable_d = 1'b1;
          mem_addr_d   = {base_q, issue_idx_next, 1'b0};
        end
        recv_inc = data_write;
        if (data_write && recv_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign fsm_busy         = (state_q == FILL);
  assign write_data_array = data_write;
  assign write_tag_array  = data_write && recv_last;
  assign word_offset      = data_write ? recv_idx : '0;
  assign data_to_cache    = mem.memory_data_in;

  assign mem.mem_enable     = mem_enable_q;
  assign mem.mem_wr         = 1'b0;
  assign mem.memory_address = mem_addr_q;

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Self-checking bench for cache_fill_fsm. A fixed-latency memory answers the
// DUT's requests; a timeline model of the fill (cycles relative to the cycle a
// miss is accepted) predicts every output each cycle. Directed scenarios add
// hand-computed literal expectations. Build with +define+
// CACHE_FILL_CRITICAL_FIRST_EN to exercise the critical-word-first variant.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;
  import cache_pkg::*;

  localparam int LAT   = MEM_LATENCY;
  localparam int DEPTH = 4096;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy, write_data_array, write_tag_array;
  logic [2:0]  word_offset;
  logic [15:0] data_to_cache;

  cache_fill_fsm_if #(.ADDR_WIDTH(16)) mem_if ();

  cache_fill_fsm #(.ADDR_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .word_offset      (word_offset),
    .data_to_cache    (data_to_cache),
    .mem              (mem_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Memory pipe: request seen in cycle c returns in cycle c+LAT.
  logic        req_v [DEPTH];
  logic [15:0] req_a [DEPTH];
  logic        inj = 1'b0;

  // Fill model state.
  logic        m_active = 1'b0;
  int          m_t0     = 0;
  logic [15:0] m_base   = 16'h0;
  int          m_start  = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    int r;
    @(posedge clk);
    #1;
    cyc++;
    r = cyc - LAT;
    mem_if.memory_data_valid = inj | ((r >= 0) ? req_v[r] : 1'b0);
    if (inj)                     mem_if.memory_data_in = 16'hDEAD;
    else if (r >= 0 && req_v[r]) mem_if.memory_data_in = mem_word(req_a[r]);
    else                         mem_if.memory_data_in = 16'h0000;
  endtask

  // Per-cycle compare against the fill timeline, then advance model and memory.
  always @(negedge clk) begin
    int          k, e_off;
    logic        in_fill, e_men, e_wr, e_tag;
    logic [15:0] e_addr, blk;
    if (cyc >= 1) begin
      k       = cyc - m_t0;
      blk     = {m_base[15:4], 4'h0};
      in_fill = m_active && k >= 1 && k <= 12;
      e_men   = m_active && k >= 1 && k <= 8;
      e_addr  = e_men ? blk + 16'(2 * ((m_start + k - 1) % 8)) : 16'h0;
      e_wr    = in_fill && k >= 5;
      e_off   = e_wr ? (m_start + k - 5) % 8 : 0;
      e_tag   = e_wr && k == 12;

      check("busy",     32'(fsm_busy),              32'(in_fill));
      check("mem_en",   32'(mem_if.mem_enable),     32'(e_men));
      check("mem_addr", 32'(mem_if.memory_address), 32'(e_addr));
      check("mem_wr",   32'(mem_if.mem_wr),         32'(0));
      check("wr_data",  32'(write_data_array),      32'(e_wr));
      check("wr_tag",   32'(write_tag_array),       32'(e_tag));
      check("offset",   32'(word_offset),           32'(e_off));
      if (e_wr) check("data", 32'(data_to_cache), 32'(mem_word(blk + 16'(2 * e_off))));

      req_v[cyc] = mem_if.mem_enable;
      req_a[cyc] = mem_if.memory_address;

      if (rst) begin
        for (int j = cyc - LAT + 1; j <= cyc; j++) if (j >= 0) req_v[j] = 1'b0;
        m_active = 1'b0;
      end else if ((!m_active || k >= 13) && miss_detected) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_base   = miss_address;
        m_start  = CRIT ? int'(miss_address[3:1]) : 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      req_v[i] = 1'b0;
      req_a[i] = 16'h0;
    end
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    mem_if.memory_data_valid = 1'b0;
    mem_if.memory_data_in    = 16'h0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle with stray valids: no strobes.
    for (int i = 0; i < 5; i++) begin
      inj = (i % 2 == 0);
      tick();
      #2;
      check("idle_wr",   32'(write_data_array), 32'(0));
      check("idle_busy", 32'(fsm_busy),         32'(0));
    end
    inj = 1'b0;
    tick();

    // Basic fill at 0x1236.
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    for (int k = 1; k <= 13; k++) begin
      tick();
      miss_detected = 1'b0;
      #2;
      if (k == 1) check("t2_addr_first", 32'(mem_if.memory_address), 32'(CRIT ? 16'h1236 : 16'h1230));
      if (k == 5 && !CRIT) check("t2_data_first", 32'(data_to_cache), 32'h486A);
      if (k == 8) check("t2_addr_last", 32'(mem_if.memory_address), 32'(CRIT ? 16'h1234 : 16'h123E));
      if (k == 12) check("t2_tag", 32'(write_tag_array), 32'(1));
      if (k == 13) check("t2_busy_fall", 32'(fsm_busy), 32'(0));
    end

    // miss_detected held high with a changing address.
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k <= 13) miss_address = 16'h2000 + 16'(k * 16'h0100);
      else         miss_detected = 1'b0;
      #2;
      if (k == 2)  check("t3_addr_first_fill", 32'(mem_if.memory_address), 32'(16'h2002));
      if (k == 13) check("t3_idle_gap", 32'(fsm_busy), 32'(0));
      if (k == 14) check("t3_addr_second_fill", 32'(mem_if.memory_address), 32'(16'h2D00));
    end

    // Reset mid-fill, then a fresh miss.
    miss_detected = 1'b1;
    miss_address  = 16'h4448;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 1)  miss_detected = 1'b0;
      if (k == 7)  rst = 1'b1;
      if (k == 8)  rst = 1'b0;
      if (k == 10) begin
        miss_detected = 1'b1;
        miss_address  = 16'h5550;
      end
      if (k == 11) miss_detected = 1'b0;
      #2;
      if (k == 8) begin
        check("t4_rst_busy", 32'(fsm_busy),              32'(0));
        check("t4_rst_men",  32'(mem_if.mem_enable),     32'(0));
        check("t4_rst_addr", 32'(mem_if.memory_address), 32'(0));
        check("t4_rst_wr",   32'(write_data_array),      32'(0));
      end
      if (k == 22) check("t4_refill_tag", 32'(write_tag_array), 32'(1));
      if (k == 23) check("t4_refill_done", 32'(fsm_busy), 32'(0));
    end

    // Miss at 0x00AC (critical-word-first ordering when enabled).
    miss_detected = 1'b1;
    miss_address  = 16'h00AC;
    for (int k = 1; k <= 13; k++) begin
      tick();
      miss_detected = 1'b0;
      #2;
      if (k == 1) check("t5_addr1", 32'(mem_if.memory_address), 32'(CRIT ? 16'h00AC : 16'h00A0));
      if (k == 3) check("t5_addr3", 32'(mem_if.memory_address), 32'(CRIT ? 16'h00A0 : 16'h00A4));
      if (k == 5) check("t5_off_first", 32'(word_offset), 32'(CRIT ? 6 : 0));
      if (k == 12) begin
        check("t5_tag",      32'(write_tag_array), 32'(1));
        check("t5_off_last", 32'(word_offset),     32'(CRIT ? 5 : 7));
      end
    end

    // Back-to-back misses at 0x0000 and 0xFFF0.
    miss_detected = 1'b1;
    miss_address  = 16'h0000;
    for (int k = 1; k <= 27; k++) begin
      tick();
      miss_detected = (k == 13);
      if (k == 13) miss_address = 16'hFFF0;
      #2;
      if (k == 12) check("t6_first_tag", 32'(write_tag_array), 32'(1));
      if (k == 14) check("t6_second_addr0", 32'(mem_if.memory_address), 32'(16'hFFF0));
      if (k == 21) check("t6_second_addr7", 32'(mem_if.memory_address), 32'(16'hFFFE));
      if (k == 25) check("t6_second_tag", 32'(write_tag_array), 32'(1));
      if (k == 26) check("t6_second_done", 32'(fsm_busy), 32'(0));
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cache_fill_fsm
